// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state codes, default frame
// constants (common with the transmitter) and small helpers.
package uart_rx_pkg;

  localparam int DEF_OVS     = 16;
  localparam int DEF_DW      = 8;
  localparam int DEF_ODD_PAR = 0;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_PARITY  = 3'd3;
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_WAIT_HI = 3'd5;

  typedef struct packed {
    logic perr;
    logic ferr;
  } rx_flags_t;

  // After the last data bit the frame continues with parity only if enabled.
  function automatic logic [2:0] state_after_data(input logic psel);
    return psel ? S_PARITY : S_STOP;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; the reset value
// is chosen so the synchronised signal reads as its idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop detection producing a
// registered byte, a one-cycle ready strobe and parity/framing flags.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int OVS     = DEF_OVS,
  parameter int DW      = DEF_DW,
  parameter int ODD_PAR = DEF_ODD_PAR
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          rx_i,
  input  logic          z_i,
  input  logic          psel_i,
  output logic [DW-1:0] data_o,
  output logic          rdy_o,
  output logic          perr_o,
  output logic          ferr_o,
  output logic          busy_o
);

  localparam int TW = $clog2(OVS);
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [TW-1:0] T_HALF  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_FULL  = TW'(OVS - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(DW - 1);
  localparam logic          ODD_BIT = (ODD_PAR != 0);

  logic          rxs;
  logic [2:0]    state;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  logic [DW-1:0] shift;
  logic          psel_q;
  logic          perr_q;
  logic          hit;
  rx_flags_t     flags_q;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .d     (rx_i),
    .q     (rxs)
  );

  // The start bit is checked at its middle; every later bit one full bit on.
  always_comb begin
    hit = 1'b0;
    if (z_i) begin
      hit = (state == S_START) ? (tcnt == T_HALF) : (tcnt == T_FULL);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= S_IDLE;
      tcnt    <= '0;
      bcnt    <= '0;
      shift   <= '0;
      psel_q  <= 1'b0;
      perr_q  <= 1'b0;
      data_o  <= '0;
      rdy_o   <= 1'b0;
      flags_q <= '0;
    end else begin
      rdy_o <= 1'b0;
      if (z_i && !hit && (state inside {S_START, S_DATA, S_PARITY, S_STOP})) begin
        tcnt <= tcnt + TW'(1);
      end
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            tcnt   <= '0;
            psel_q <= psel_i;
            state  <= S_START;
          end
        end
        S_START: begin
          if (hit) begin
            if (rxs) begin
              state <= S_IDLE;
            end else begin
              tcnt  <= '0;
              bcnt  <= '0;
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (hit) begin
            shift <= {rxs, shift[DW-1:1]};
            tcnt  <= '0;
            if (bcnt == B_LAST) begin
              state <= state_after_data(psel_q);
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end
        end
        S_PARITY: begin
          if (hit) begin
            perr_q <= (^shift) ^ rxs ^ ODD_BIT;
            tcnt   <= '0;
            state  <= S_STOP;
          end
        end
        S_STOP: begin
          if (hit) begin
            data_o       <= shift;
            flags_q.perr <= psel_q & perr_q;
            flags_q.ferr <= ~rxs;
            rdy_o        <= 1'b1;
            tcnt         <= '0;
            // A low stop bit may be a break; wait for the line to recover.
            state        <= rxs ? S_IDLE : S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (rxs) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign perr_o = flags_q.perr;
  assign ferr_o = flags_q.ferr;
  assign busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed vector table, multi-cycle corner
// sequences and random frames against a frame-level reference model.
module tb_uart_rx;

  localparam int OVS     = 16;
  localparam int DW      = 8;
  localparam int ODD_PAR = 0;
  localparam int TDIV    = 3;

  logic          clk_i  = 1'b0;
  logic          rst_ni = 1'b0;
  logic          rx_i   = 1'b1;
  logic          z_i    = 1'b0;
  logic          psel_i = 1'b0;
  logic [DW-1:0] data_o;
  logic          rdy_o;
  logic          perr_o;
  logic          ferr_o;
  logic          busy_o;

  int total = 0;
  int bad   = 0;
  int tick_cnt   = 0;
  int start_tick = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         tick;
  } obs_t;

  typedef struct {
    logic [7:0] data;
    logic       psel;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  exp_t exp_q[$];
  obs_t got_q[$];
  exp_t last_exp;
  vec_t vecs[6];

  uart_rx #(.OVS(OVS), .DW(DW), .ODD_PAR(ODD_PAR)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .rx_i   (rx_i),
    .z_i    (z_i),
    .psel_i (psel_i),
    .data_o (data_o),
    .rdy_o  (rdy_o),
    .perr_o (perr_o),
    .ferr_o (ferr_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Time-base tick: one clock wide every TDIV clocks, changed just after posedge.
  initial begin : tick_gen
    int phase;
    phase = 0;
    forever begin
      @(posedge clk_i);
      #2;
      phase = (phase == TDIV - 1) ? 0 : phase + 1;
      z_i = (phase == 0);
      if (z_i) tick_cnt++;
    end
  end

  always @(negedge clk_i) begin
    if (rdy_o) got_q.push_back('{data_o, perr_o, ferr_o, tick_cnt});
  end

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      @(negedge clk_i);
      while (!z_i && guard < 10) begin
        @(negedge clk_i);
        guard++;
      end
      if (guard >= 10) check("tick_wait", 32'd0, 32'd1);
    end
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (($countones(d) % 2) != ODD_PAR);
  endfunction

  // Frame-level reference: what the receiver must report for a given frame.
  function automatic exp_t model(input logic [7:0] d, input logic psel,
                                 input logic par, input logic stop);
    exp_t e;
    int ones;
    ones   = $countones(d) + int'(par);
    e.data = d;
    e.perr = psel ? ((ones % 2) != ODD_PAR) : 1'b0;
    e.ferr = ~stop;
    return e;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic psel,
                            input logic par, input logic stop);
    psel_i     = psel;
    rx_i       = 1'b0;
    start_tick = tick_cnt;
    wait_ticks(OVS);
    for (int i = 0; i < DW; i++) begin
      rx_i = d[i];
      wait_ticks(OVS);
    end
    if (psel) begin
      rx_i = par;
      wait_ticks(OVS);
    end
    rx_i = stop;
    wait_ticks(OVS);
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    wait_ticks(n);
  endtask

  task automatic check_frames(input string name);
    exp_t e;
    obs_t g;
    check({name, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({name, "_data"}, g.data, e.data);
      check({name, "_perr"}, g.perr, e.perr);
      check({name, "_ferr"}, g.ferr, e.ferr);
      last_exp = e;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic check_held(input string name);
    check({name, "_data"}, data_o, last_exp.data);
    check({name, "_perr"}, perr_o, last_exp.perr);
    check({name, "_ferr"}, ferr_o, last_exp.ferr);
  endtask

  initial begin : main
    int lat;
    logic [7:0] d;
    logic ps, par, stop;

    vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[1] = '{8'hA3, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0};
    vecs[2] = '{8'hA3, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0};
    vecs[3] = '{8'h01, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};

    rst_ni = 1'b0;
    repeat (5) @(negedge clk_i);
    check("reset_data", data_o, 8'h00);
    check("reset_rdy",  rdy_o,  1'b0);
    check("reset_perr", perr_o, 1'b0);
    check("reset_ferr", ferr_o, 1'b0);
    check("reset_busy", busy_o, 1'b0);
    rst_ni = 1'b1;
    idle(OVS);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].psel, vecs[i].par, vecs[i].stop);
      exp_q.push_back('{vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr});
      if (i == 0 && got_q.size() > 0) begin
        lat = got_q[0].tick - start_tick;
        check("latency_in_window", (lat >= 150 && lat <= 155), 1'b1);
      end
      idle(OVS);
      check_frames($sformatf("vec%0d", i));
    end

    // Short low glitch: must be rejected as a false start.
    rx_i = 1'b0;
    wait_ticks(2);
    check("glitch_busy_high", busy_o, 1'b1);
    wait_ticks(2);
    idle(OVS);
    check("glitch_busy_low", busy_o, 1'b0);
    check_frames("glitch");
    check_held("glitch_hold");

    // Low stop bit followed by a long break, then a normal frame.
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(model(8'h0F, 1'b0, 1'b0, 1'b0));
    wait_ticks(3 * OVS);
    check("break_busy", busy_o, 1'b1);
    check_frames("break");
    idle(OVS);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(model(8'h3C, 1'b0, 1'b0, 1'b1));
    idle(OVS);
    check_frames("after_break");

    // Reset pulse in the middle of data bit 4.
    psel_i = 1'b0;
    rx_i = 1'b0;
    wait_ticks(OVS);
    rx_i = 1'b1;
    wait_ticks(4 * OVS + OVS / 2);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    check("midrst_data", data_o, 8'h00);
    check("midrst_perr", perr_o, 1'b0);
    check("midrst_ferr", ferr_o, 1'b0);
    check("midrst_busy", busy_o, 1'b0);
    idle(2 * OVS);
    check("midrst_no_rdy", got_q.size(), 32'd0);
    got_q.delete();
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(model(8'h81, 1'b0, 1'b0, 1'b1));
    idle(OVS);
    check_frames("after_rst");

    // Back-to-back frames with no idle gap.
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(model(8'h12, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(model(8'h34, 1'b0, 1'b0, 1'b1));
    idle(OVS);
    check_frames("b2b");

    for (int n = 0; n < 30; n++) begin
      d    = 8'($urandom);
      ps   = 1'($urandom_range(0, 1));
      par  = good_par(d) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 7) != 0);
      send_frame(d, ps, par, stop);
      exp_q.push_back(model(d, ps, par, stop));
      idle(stop ? $urandom_range(0, OVS) : $urandom_range(2, OVS));
      check_frames($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the counterpart of the team's UART transmitter FSM.
- Deserialises an asynchronous line into 8-bit bytes using an oversampling time-base tick.
- Validates the start bit, the optional parity bit and the stop bit.
- Presents the byte with a one-cycle ready strobe and error flags to the downstream logic (display/register block) on the FPGA board.

Parameters:
- OVS, 16, oversampling ticks per bit; must be even and >= 4.
- DW, 8, data bits per frame, LSB first.
- ODD_PAR, 0, parity sense when parity is enabled: 0 = even, 1 = odd.

Ports:
- clk_i  in  1  board clock; the single clock of the block.
- rst_ni  in  1  reset, synchronous, active-low.
- rx_i  in  1  asynchronous serial line; idles high.
- z_i  in  1  time-base tick from the clock divider, one clk_i wide, at OVS x baud.
- psel_i  in  1  parity enable: 1 = frame carries a parity bit after the data.
- data_o  out  DW  last received byte.
- rdy_o  out  1  one-cycle strobe: frame complete, data_o and flags valid.
- perr_o  out  1  parity error of the last frame.
- ferr_o  out  1  framing error of the last frame (stop bit sampled low).
- busy_o  out  1  high while a frame is being received.

Behaviour:
- **Clock and reset:** one clock, clk_i. Reset rst_ni is synchronous and active-low. All registers update on posedge clk_i only.
- **Reset values:** data_o=0, rdy_o=0, perr_o=0, ferr_o=0, busy_o=0, FSM=IDLE, all counters=0. Both synchroniser flops reset to 1, so the line reads as idle.
- **Input synchronisation:** rx_i passes through a 2-flop synchroniser, giving rxs. The FSM sees only rxs, so input latency is 2 clk_i.
- **Counters:**
  - Tick counter tcnt, width $clog2(OVS), advances only on z_i.
  - Bit counter bcnt, 3 bits for DW=8.
- **IDLE:** busy_o=0. When rxs=0, clear tcnt, latch psel_i into psel_q and go to START. psel_i is ignored for the rest of the frame.
- **START:** busy_o=1. On each z_i, tcnt increments. When z_i arrives with tcnt=OVS/2-1 (mid start bit):
  - rxs=1: false start, go to IDLE; no rdy_o, flags unchanged.
  - rxs=0: clear tcnt and bcnt, go to DATA.
- **DATA:** on z_i with tcnt=OVS-1 (mid-bit):
  - Shift rxs into the MSB of the shift register (right shift, LSB first) and clear tcnt.
  - If bcnt=DW-1, go to PARITY when psel_q=1, otherwise to STOP. Else increment bcnt.
- **PARITY:** on the mid-bit tick, compute perr_q = XOR(shift, rxs) XOR ODD_PAR. For even parity the error is a nonzero XOR. Then go to STOP.
- **STOP:** on the mid-bit tick:
  - data_o <= shift. perr_o <= perr_q when psel_q=1, else 0. ferr_o <= ~rxs. rdy_o pulses high for exactly one clk_i.
  - rxs=1: go to IDLE.
  - rxs=0: go to WAIT_HI.
- **WAIT_HI:** break/framing recovery. busy_o=1. Stay until rxs=1, then go to IDLE. No new start bit is detected while in this state.
- **Output timing:** data_o and the flags are registered and hold until the next rdy_o. rdy_o rises the clk_i after the stop-bit mid-sample tick.
- **Ticks outside a frame:** z_i in IDLE or WAIT_HI has no effect.
- **Reset mid-frame:** rst_ni=0 on any edge aborts the frame. Reset values apply the next cycle, with no rdy_o. After release, reception needs a fresh falling edge on the line.
- **Line already low at reset release:** treated as a start after 2 clk_i (synchroniser refill).
- **Frame length:** start + DW + psel_q + stop bits. The receiver returns to IDLE half a bit before the stop bit ends, so back-to-back frames are accepted.

Decomposition:
- Shared include uart_defs.vh holds:
  - state encodings IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, WAIT_HI=5;
  - default OVS, DW and parity constants, shared with the transmitter.
- One natural sub-module, sync_2ff: a 2-flop synchroniser with a reset value parameter. It is reused by other async board inputs.

Test Plan:
- Frame 0x55, psel_i=0, OVS=16 → one rdy_o pulse about 152 ticks after the start edge; data_o=0x55, perr_o=0, ferr_o=0.
- Frame 0xA3 with correct even parity bit 0, psel_i=1 → data_o=0xA3, perr_o=0. Repeat with parity bit 1 → perr_o=1, data_o still 0xA3.
- Stop bit driven low for frame 0x0F, line then held low 3 bit times → rdy_o with ferr_o=1. No second rdy_o while the line is low; the next frame 0x3C after the line returns high is received correctly.
- Low glitch on rx_i of 4 ticks (< OVS/2) → no rdy_o, busy_o back to 0, outputs unchanged.
- rst_ni=0 for one cycle during bit 4 of frame 0xFF → no rdy_o, all outputs 0. The following frame 0x81 yields data_o=0x81.
- Back-to-back frames 0x12 then 0x34 with no idle gap → two rdy_o pulses with correct data and no errors.
